// File: rtl/sdc_reg_pkg.sv
// Shared constants and helpers for the SD-card controller register primitives.
// Imported by the byte-lane register, its interface and the word register top.
package sdc_reg_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_BYTES = 4;
    localparam int DEF_SEL_W     = 2;

    // Number of byte lanes needed to hold a word of the given bit width.
    function automatic int lanes_for_width(input int width);
        return (width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/byte_enable_register_if.sv
// Bus bundle for a byte-writable word register: byte write path plus
// full-word and selected-lane readback.
interface byte_enable_register_if
    import sdc_reg_pkg::*;
#(
    parameter int NUM_BYTES = DEF_NUM_BYTES,
    parameter int SEL_W     = DEF_SEL_W
);
    logic                          we;
    logic [SEL_W-1:0]              byte_sel;
    logic [BYTE_W-1:0]             byte_in;
    logic [BYTE_W-1:0]             q_byte;
    logic [NUM_BYTES*BYTE_W-1:0]   q;

    modport master (
        output we,
        output byte_sel,
        output byte_in,
        input  q_byte,
        input  q
    );

    modport slave (
        input  we,
        input  byte_sel,
        input  byte_in,
        output q_byte,
        output q
    );
endinterface

// File: rtl/byte_lane_reg.sv
// One 8-bit lane of the word register: synchronous reset value and load enable.
module byte_lane_reg
    import sdc_reg_pkg::*;
#(
    parameter logic [BYTE_W-1:0] RESET_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BYTE_W-1:0] d,
    output logic [BYTE_W-1:0] q
);
    logic [BYTE_W-1:0] q_q;
    logic [BYTE_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    // Reset wins over a coincident load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RESET_VALUE;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/byte_enable_register.sv
// Word register written one byte lane per cycle; exposes the full word and
// a combinational readback of the currently selected lane.
module byte_enable_register
    import sdc_reg_pkg::*;
#(
    parameter int                            NUM_BYTES   = DEF_NUM_BYTES,
    parameter int                            SEL_W       = DEF_SEL_W,
    parameter logic [NUM_BYTES*BYTE_W-1:0]   RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_enable_register_if.slave bus
);
    localparam int NUM_LANES = lanes_for_width(NUM_BYTES * BYTE_W);

    logic [NUM_LANES*BYTE_W-1:0] word;
    logic                        sel_in_range;
    logic [BYTE_W-1:0]           q_byte_mux;

    // Selectors past the last lane must neither write nor read anything.
    assign sel_in_range = (int'(bus.byte_sel) < NUM_LANES);

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic lane_load;

        assign lane_load = bus.we && sel_in_range && (int'(bus.byte_sel) == gi);

        byte_lane_reg #(
            .RESET_VALUE (RESET_VALUE[gi*BYTE_W +: BYTE_W])
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .load (lane_load),
            .d    (bus.byte_in),
            .q    (word[gi*BYTE_W +: BYTE_W])
        );
    end

    always_comb begin
        q_byte_mux = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (sel_in_range && (int'(bus.byte_sel) == i)) begin
                q_byte_mux = word[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign bus.q      = word;
    assign bus.q_byte = q_byte_mux;
endmodule

// File: tb/tb_byte_enable_register.sv
// Self-checking bench: three register configurations share one stimulus stream
// and are compared every cycle against a lane-array reference model.
module tb_byte_enable_register;
    import sdc_reg_pkg::*;

    localparam logic [31:0] RV0 = 32'h0000_0000;
    localparam logic [31:0] RV1 = 32'hDEAD_BEEF;
    localparam logic [23:0] RV2 = 24'h12_3456;

    logic       clk;
    logic       rst_s;
    logic       we_s;
    logic [1:0] sel_s;
    logic [7:0] din_s;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit chk_en   = 0;

    byte_enable_register_if #(.NUM_BYTES(4), .SEL_W(2)) if0 ();
    byte_enable_register_if #(.NUM_BYTES(4), .SEL_W(2)) if1 ();
    byte_enable_register_if #(.NUM_BYTES(3), .SEL_W(2)) if2 ();

    assign if0.we = we_s;  assign if0.byte_sel = sel_s;  assign if0.byte_in = din_s;
    assign if1.we = we_s;  assign if1.byte_sel = sel_s;  assign if1.byte_in = din_s;
    assign if2.we = we_s;  assign if2.byte_sel = sel_s;  assign if2.byte_in = din_s;

    byte_enable_register #(.NUM_BYTES(4), .SEL_W(2), .RESET_VALUE(RV0))
        dut0 (.clk(clk), .rst(rst_s), .bus(if0));
    byte_enable_register #(.NUM_BYTES(4), .SEL_W(2), .RESET_VALUE(RV1))
        dut1 (.clk(clk), .rst(rst_s), .bus(if1));
    byte_enable_register #(.NUM_BYTES(3), .SEL_W(2), .RESET_VALUE(RV2))
        dut2 (.clk(clk), .rst(rst_s), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each configuration is an array of byte lanes.
    int         nb [3] = '{4, 4, 3};
    logic [7:0] lanes [3][4];

    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < nb[k]; i++) w[i*8 +: 8] = lanes[k][i];
        return w;
    endfunction

    function automatic logic [7:0] model_byte(input int k, input int sel);
        if (sel >= nb[k]) return 8'h00;
        return lanes[k][sel];
    endfunction

    function automatic logic [7:0] rv_byte(input int k, input int i);
        logic [31:0] r;
        r = (k == 0) ? RV0 : (k == 1) ? RV1 : {8'h00, RV2};
        return r[i*8 +: 8];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst_s) begin
                for (int i = 0; i < 4; i++) lanes[k][i] = rv_byte(k, i);
            end else if (we_s && int'(sel_s) < nb[k]) begin
                lanes[k][int'(sel_s)] = din_s;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Per-cycle comparison of all outputs, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_q0",  if0.q, model_word(0));
            check("cyc_q1",  if1.q, model_word(1));
            check("cyc_q2",  {8'h00, if2.q}, model_word(2));
            check("cyc_qb0", {24'h0, if0.q_byte}, {24'h0, model_byte(0, int'(sel_s))});
            check("cyc_qb1", {24'h0, if1.q_byte}, {24'h0, model_byte(1, int'(sel_s))});
            check("cyc_qb2", {24'h0, if2.q_byte}, {24'h0, model_byte(2, int'(sel_s))});
        end
    end

    // Drive one cycle of inputs, then return just after the edge that samples them.
    task automatic step(input logic r, input logic w, input logic [1:0] s, input logic [7:0] d);
        @(negedge clk);
        #1;
        rst_s = r; we_s = w; sel_s = s; din_s = d;
        @(posedge clk);
        #1;
        $display("txn rst=%0b we=%0b sel=%0d din=%h -> q0=%h q1=%h q2=%h",
                 r, w, s, d, if0.q, if1.q, if2.q);
    endtask

    initial begin
        rst_s = 1'b1; we_s = 1'b0; sel_s = '0; din_s = '0;

        step(1'b1, 1'b0, 2'd0, 8'h00);
        chk_en = 1;
        check("reset_q0",  if0.q, 32'h0000_0000);
        check("reset_qb0", {24'h0, if0.q_byte}, 32'h00);
        check("reset_q1",  if1.q, 32'hDEAD_BEEF);
        check("reset_qb1", {24'h0, if1.q_byte}, 32'hEF);
        check("reset_q2",  {8'h00, if2.q}, 32'h0012_3456);

        step(1'b0, 1'b1, 2'd0, 8'hAB);
        check("lane0_q0",  if0.q, 32'h0000_00AB);
        check("lane0_qb0", {24'h0, if0.q_byte}, 32'hAB);
        check("lane0_q2",  {8'h00, if2.q}, 32'h0012_34AB);

        step(1'b0, 1'b1, 2'd3, 8'hAB);
        check("lane3_q0",  if0.q, 32'hAB00_00AB);
        check("lane3_qb0", {24'h0, if0.q_byte}, 32'hAB);
        check("lane3_q1",  if1.q, 32'hABAD_BEAB);
        check("lane3_q2",  {8'h00, if2.q}, 32'h0012_34AB);
        check("lane3_qb2", {24'h0, if2.q_byte}, 32'h00);

        sel_s = 2'd1;
        #1;
        check("comb_qb0", {24'h0, if0.q_byte}, 32'h00);
        check("comb_qb1", {24'h0, if1.q_byte}, 32'hBE);

        step(1'b0, 1'b1, 2'd0, 8'h11);
        step(1'b0, 1'b1, 2'd1, 8'h22);
        step(1'b0, 1'b1, 2'd2, 8'h33);
        step(1'b0, 1'b1, 2'd3, 8'h44);
        check("b2b_q0", if0.q, 32'h4433_2211);
        check("b2b_q2", {8'h00, if2.q}, 32'h0033_2211);

        step(1'b0, 1'b1, 2'd2, 8'hFF);
        check("rewrite_q0", if0.q, 32'h44FF_2211);
        check("rewrite_q2", {8'h00, if2.q}, 32'h00FF_2211);

        step(1'b1, 1'b1, 2'd1, 8'h55);
        check("rstprio_q0", if0.q, 32'h0000_0000);
        check("rstprio_q1", if1.q, 32'hDEAD_BEEF);
        check("rstprio_q2", {8'h00, if2.q}, 32'h0012_3456);

        step(1'b0, 1'b1, 2'd3, 8'h77);
        check("oor_q2",  {8'h00, if2.q}, 32'h0012_3456);
        check("oor_qb2", {24'h0, if2.q_byte}, 32'h00);
        check("oor_q0",  if0.q, 32'h7700_0000);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) != 0,
                 2'($urandom_range(0, 3)), 8'($urandom));
        end

        step(1'b0, 1'b0, 2'd0, 8'h00);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/byte_enable_register.md
Name: byte_enable_register

Overview:
- Word-wide storage register written one byte lane at a time, with the selected lane readable back.
- Used as the basic control/status register primitive inside the SD-card controller register file.
- A single 8-bit write path plus a lane selector updates exactly one byte; all other lanes hold their value.
- Exposes the full word and the currently selected byte.

Parameters:
- NUM_BYTES, 4, number of byte lanes; word width is NUM_BYTES*8. Legal range is 1..16.
- SEL_W, 2, width of byte_sel; must satisfy 2**SEL_W >= NUM_BYTES.
- RESET_VALUE, 0 (NUM_BYTES*8 bits), word value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable; sampled on the rising edge of clk.
- byte_sel  input  SEL_W  lane index; 0 is bits [7:0], 3 is bits [31:24].
- byte_in  input  8  write data for the selected lane.
- q_byte  output  8  current content of lane byte_sel (combinational readback).
- q  output  NUM_BYTES*8  full registered word.

Behaviour:
- Reset: if rst=1 at a rising edge, q <= RESET_VALUE. Reset has priority over we. q_byte then follows the reset contents.
- Write: if rst=0 and we=1 at a rising edge, lane byte_sel <= byte_in.
  - All other lanes are unchanged.
  - Latency is 1 cycle: new data is visible on q and q_byte after that edge.
- Hold: if we=0, q is unchanged. byte_sel and byte_in are don't-care for state.
- Readback: q_byte = q[byte_sel*8 +: 8]. It is purely combinational with no added latency, and it changes immediately when byte_sel changes.
- Out-of-range byte_sel (byte_sel >= NUM_BYTES):
  - A write is ignored and no lane changes.
  - q_byte = 8'h00.
- Back-to-back writes on consecutive cycles to different lanes all take effect.
- Back-to-back writes to the same lane: the last write wins.
- Reset mid-operation: rst and we asserted on the same edge yields RESET_VALUE. The write is discarded.
- No X-propagation from byte_in into unselected lanes.
- No handshake, no busy state. A write is accepted every cycle we=1.

Decomposition:
- Shared package sdc_reg_pkg holds:
  - BYTE_W = 8.
  - a helper function for the lane count from a word width.
  - the default NUM_BYTES and SEL_W constants used by the controller register file.
- One natural sub-module: byte_lane_reg. It is an 8-bit register with a synchronous reset value and a load enable. It is instantiated NUM_BYTES times via generate, with load = we & (byte_sel == i) & in-range.
- The readback mux lives in the top module.

Test Plan:
- Reset: pulse rst for 1 cycle with we=0 -> q=32'h00000000, q_byte=8'h00.
- Lane 0 write: byte_sel=0, byte_in=8'hAB, we for 1 cycle -> q=32'h000000AB and q_byte=8'hAB on the next cycle.
- Lane 3 write after lane 0: byte_sel=3, byte_in=8'hAB, we for 1 cycle -> q=32'hAB0000AB, q_byte=8'hAB. Then byte_sel=1 gives q_byte=8'h00 combinationally.
- Back-to-back writes: lanes 0..3 with 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles -> q=32'h44332211. Then rewrite lane 2 with 8'hFF -> q=32'h44FF2211.
- Reset priority: rst=1 and we=1 (byte_sel=1, byte_in=8'h55) on the same edge -> q=RESET_VALUE. Repeat with RESET_VALUE=32'hDEADBEEF -> q=32'hDEADBEEF.
- Out-of-range lane: NUM_BYTES=3, SEL_W=2, write byte_sel=3 with 8'h77 -> q unchanged, q_byte=8'h00.
